// File: rtl/barrel_shift_pipe.sv
// Pipelined ARM-style operand-2 barrel shifter: stage 1 decodes the shift and resolves
// special amounts, and the log2(WIDTH) mux levels are spread across STAGES registered stages.
module barrel_shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int AMT_W  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_type,
  input  logic             in_imm,
  input  logic [WIDTH-1:0] in_a,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_carry,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LOGW = $clog2(WIDTH);
  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Applies the mux levels lo..hi-1 selected by the set bits of amt.
  function automatic logic [WIDTH-1:0] shift_levels(
    input logic [WIDTH-1:0] x,
    input logic [1:0]       kind,
    input logic [LOGW-1:0]  amt,
    input int               lo,
    input int               hi
  );
    logic [WIDTH-1:0] y;
    y = x;
    for (int j = 0; j < LOGW; j++) begin
      if (j >= lo && j < hi && amt[j]) begin
        case (kind)
          OP_LSL:  y = y << (1 << j);
          OP_LSR:  y = y >> (1 << j);
          OP_ASR:  y = $signed(y) >>> (1 << j);
          default: y = (y >> (1 << j)) | (y << (WIDTH - (1 << j)));
        endcase
      end
    end
    return y;
  endfunction

  logic [LOGW-1:0]  nl;
  logic [LOGW-1:0]  idx_r;
  logic [LOGW-1:0]  idx_l;
  logic             n_lt_w;
  logic             n_zero;
  logic             n_eq_w;
  logic             sign;
  logic [WIDTH-1:0] dec_d;
  logic [LOGW-1:0]  dec_amt;
  logic             dec_c;

  // Every case that yields a fixed result is folded here to amount 0, so later levels pass it through.
  always_comb begin
    nl      = in_amt[LOGW-1:0];
    idx_r   = nl - 1'b1;
    idx_l   = '0 - nl;
    n_lt_w  = in_imm || (in_amt[AMT_W-1:LOGW] == '0);
    n_zero  = n_lt_w && (nl == '0);
    n_eq_w  = !in_imm && (in_amt == AMT_W'(WIDTH));
    sign    = in_a[WIDTH-1];
    dec_d   = in_a;
    dec_amt = nl;
    dec_c   = in_a[idx_r];
    if (n_zero) begin
      dec_amt = '0;
      dec_c   = in_carry;
      if (in_imm) begin
        case (in_type)
          OP_LSR: begin
            dec_d = '0;
            dec_c = sign;
          end
          OP_ASR: begin
            dec_d = {WIDTH{sign}};
            dec_c = sign;
          end
          OP_ROR: begin
            dec_d = {in_carry, in_a[WIDTH-1:1]};
            dec_c = in_a[0];
          end
          default: ;
        endcase
      end
    end else begin
      case (in_type)
        OP_LSL: begin
          if (n_lt_w) begin
            dec_c = in_a[idx_l];
          end else begin
            dec_amt = '0;
            dec_d   = '0;
            dec_c   = n_eq_w ? in_a[0] : 1'b0;
          end
        end
        OP_LSR: begin
          if (!n_lt_w) begin
            dec_amt = '0;
            dec_d   = '0;
            dec_c   = n_eq_w ? sign : 1'b0;
          end
        end
        OP_ASR: begin
          if (!n_lt_w) begin
            dec_amt = '0;
            dec_d   = {WIDTH{sign}};
            dec_c   = sign;
          end
        end
        default: begin
          // Nonzero register amount that is a multiple of WIDTH: value unchanged, carry is the MSB.
          if (nl == '0) begin
            dec_amt = '0;
            dec_c   = sign;
          end
        end
      endcase
    end
  end

  logic             v_reg    [STAGES];
  logic [WIDTH-1:0] d_reg    [STAGES];
  logic             c_reg    [STAGES];
  logic [TAG_W-1:0] tag_reg  [STAGES];
  logic [1:0]       kind_reg [STAGES];
  logic [LOGW-1:0]  amt_reg  [STAGES];

  logic             v_next    [STAGES];
  logic [WIDTH-1:0] d_next    [STAGES];
  logic             c_next    [STAGES];
  logic [TAG_W-1:0] tag_next  [STAGES];
  logic [1:0]       kind_next [STAGES];
  logic [LOGW-1:0]  amt_next  [STAGES];

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * LOGW / STAGES;
      localparam int HI = (gi + 1) * LOGW / STAGES;
      if (gi == 0) begin : g_first
        assign v_next[gi]    = in_valid;
        assign d_next[gi]    = shift_levels(dec_d, in_type, dec_amt, LO, HI);
        assign c_next[gi]    = dec_c;
        assign tag_next[gi]  = in_tag;
        assign kind_next[gi] = in_type;
        assign amt_next[gi]  = dec_amt;
      end else begin : g_rest
        assign v_next[gi]    = v_reg[gi-1];
        assign d_next[gi]    = shift_levels(d_reg[gi-1], kind_reg[gi-1], amt_reg[gi-1], LO, HI);
        assign c_next[gi]    = c_reg[gi-1];
        assign tag_next[gi]  = tag_reg[gi-1];
        assign kind_next[gi] = kind_reg[gi-1];
        assign amt_next[gi]  = amt_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        v_reg[i]    <= 1'b0;
        d_reg[i]    <= '0;
        c_reg[i]    <= 1'b0;
        tag_reg[i]  <= '0;
        kind_reg[i] <= '0;
        amt_reg[i]  <= '0;
      end
    end else if (adv) begin
      for (int i = 0; i < STAGES; i++) begin
        v_reg[i]    <= v_next[i];
        d_reg[i]    <= d_next[i];
        c_reg[i]    <= c_next[i];
        tag_reg[i]  <= tag_next[i];
        kind_reg[i] <= kind_next[i];
        amt_reg[i]  <= amt_next[i];
      end
    end
  end

  assign out_valid = v_reg[STAGES-1];
  assign out_b     = d_reg[STAGES-1];
  assign out_carry = c_reg[STAGES-1];
  assign out_tag   = tag_reg[STAGES-1];

  // The final stage has no further mux levels to steer.
  logic unused_last;
  assign unused_last = ^{kind_reg[STAGES-1], amt_reg[STAGES-1]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed and model-based bench for barrel_shift_pipe at WIDTH=32; STAGES may be overridden.
module tb_barrel_shift_pipe;
  localparam int WIDTH = 32;
  localparam int AMT_W = 8;
  localparam int TAG_W = 4;
  parameter int STAGES = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic        in_imm;
  logic [31:0] in_a;
  logic [7:0]  in_amt;
  logic        in_carry;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_b;
  logic        out_carry;
  logic [3:0]  out_tag;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]  ty;
    logic        imm;
    logic [31:0] a;
    logic [7:0]  amt;
    logic        cin;
    logic [31:0] b;
    logic        c;
  } vec_t;

  barrel_shift_pipe #(.WIDTH(WIDTH), .AMT_W(AMT_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_imm(in_imm),
    .in_a(in_a), .in_amt(in_amt), .in_carry(in_carry), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_b(out_b),
    .out_carry(out_carry), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: shifts one bit at a time, carry = last bit shifted out.
  function automatic void ref_shift(input logic [1:0] ty, input logic imm, input logic [31:0] a,
                                    input logic [7:0] amt, input logic cin,
                                    output logic [31:0] b, output logic c);
    int n;
    n = imm ? int'(amt[4:0]) : int'(amt);
    b = a;
    c = cin;
    if (imm && n == 0) begin
      case (ty)
        2'b01: begin b = 32'h0; c = a[31]; end
        2'b10: begin b = {32{a[31]}}; c = a[31]; end
        2'b11: begin b = {cin, a[31:1]}; c = a[0]; end
        default: ;
      endcase
    end else begin
      for (int s = 0; s < n; s++) begin
        case (ty)
          2'b00: begin c = b[31]; b = b << 1; end
          2'b01: begin c = b[0]; b = b >> 1; end
          2'b10: begin c = b[0]; b = {b[31], b[31:1]}; end
          default: begin c = b[0]; b = {b[0], b[31:1]}; end
        endcase
      end
    end
  endfunction

  // Offers one op and waits for its result; lat is cycles from the accept cycle to out_valid.
  task automatic run_op(input logic [1:0] ty, input logic imm, input logic [31:0] a,
                        input logic [7:0] amt, input logic cin, input logic [3:0] tag,
                        output logic [31:0] b, output logic c, output logic [3:0] tg,
                        output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_type   = ty;
    in_imm    = imm;
    in_a      = a;
    in_amt    = amt;
    in_carry  = cin;
    in_tag    = tag;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 40);
    b  = out_b;
    c  = out_carry;
    tg = out_tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_type = 2'b00; in_imm = 1'b0; in_a = '0; in_amt = '0; in_carry = 1'b0; in_tag = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out_b !== 32'h0 || out_carry !== 1'b0 || out_tag !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b b=%h c=%b t=%h, want all 0", out_valid, out_b, out_carry, out_tag);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_vectors(input string name, input vec_t tv[]);
    logic [31:0] b;
    logic c;
    logic [3:0] tg;
    int lat;
    foreach (tv[i]) begin
      run_op(tv[i].ty, tv[i].imm, tv[i].a, tv[i].amt, tv[i].cin, 4'(i), b, c, tg, lat);
      vectors++;
      if (b !== tv[i].b || c !== tv[i].c || tg !== 4'(i) || lat != STAGES) begin
        miscompares++;
        $display("FAIL %s[%0d]: got b=%h c=%b tag=%h lat=%0d, want b=%h c=%b tag=%h lat=%0d",
                 name, i, b, c, tg, lat, tv[i].b, tv[i].c, 4'(i), STAGES);
      end
    end
  endtask

  task automatic test_imm();
    vec_t tv[];
    tv = new[9];
    tv[0] = '{2'b00, 1'b1, 32'hFFFFFFFF, 8'd1,  1'b0, 32'hFFFFFFFE, 1'b1};
    tv[1] = '{2'b00, 1'b1, 32'h12345678, 8'd0,  1'b1, 32'h12345678, 1'b1};
    tv[2] = '{2'b01, 1'b1, 32'h80000FFF, 8'd0,  1'b0, 32'h00000000, 1'b1};
    tv[3] = '{2'b10, 1'b1, 32'h80000FFF, 8'd0,  1'b0, 32'hFFFFFFFF, 1'b1};
    tv[4] = '{2'b11, 1'b1, 32'h00000FFF, 8'd0,  1'b1, 32'h800007FF, 1'b1};
    tv[5] = '{2'b01, 1'b1, 32'h80000FFF, 8'd4,  1'b0, 32'h080000FF, 1'b1};
    tv[6] = '{2'b10, 1'b1, 32'h80000FFF, 8'd4,  1'b0, 32'hF80000FF, 1'b1};
    tv[7] = '{2'b11, 1'b1, 32'h80000FFF, 8'd8,  1'b0, 32'hFF80000F, 1'b1};
    tv[8] = '{2'b00, 1'b1, 32'h80000FFF, 8'd36, 1'b1, 32'h0000FFF0, 1'b0};
    test_vectors("imm", tv);
  endtask

  task automatic test_reg();
    vec_t tv[];
    tv = new[10];
    tv[0] = '{2'b00, 1'b0, 32'h00000001, 8'd32,  1'b0, 32'h00000000, 1'b1};
    tv[1] = '{2'b00, 1'b0, 32'h00000001, 8'd33,  1'b1, 32'h00000000, 1'b0};
    tv[2] = '{2'b01, 1'b0, 32'hFFFFFFFF, 8'd40,  1'b1, 32'h00000000, 1'b0};
    tv[3] = '{2'b10, 1'b0, 32'h80000000, 8'd200, 1'b0, 32'hFFFFFFFF, 1'b1};
    tv[4] = '{2'b11, 1'b0, 32'h80000001, 8'd64,  1'b0, 32'h80000001, 1'b1};
    tv[5] = '{2'b11, 1'b0, 32'hFFF000FF, 8'd36,  1'b0, 32'hFFFF000F, 1'b1};
    tv[6] = '{2'b10, 1'b0, 32'h80000000, 8'd0,   1'b1, 32'h80000000, 1'b1};
    tv[7] = '{2'b01, 1'b0, 32'h80000000, 8'd32,  1'b0, 32'h00000000, 1'b1};
    tv[8] = '{2'b00, 1'b0, 32'h00000003, 8'd31,  1'b0, 32'h80000000, 1'b1};
    tv[9] = '{2'b11, 1'b0, 32'h0000000F, 8'd0,   1'b0, 32'h0000000F, 1'b0};
    test_vectors("reg", tv);
  endtask

  task automatic test_backpressure();
    int idx, got, stall;
    logic first_seen;
    logic [31:0] hold_b;
    logic hold_c;
    logic [3:0] hold_tag;
    idx = 0; got = 0; stall = 0; first_seen = 1'b0;
    hold_b = '0; hold_c = 1'b0; hold_tag = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        stall = 3;
        hold_b = out_b; hold_c = out_carry; hold_tag = out_tag;
      end else if (stall > 0) begin
        vectors++;
        if (out_b !== hold_b || out_carry !== hold_c || out_tag !== hold_tag || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL bp_stable: got v=%b b=%h c=%b t=%h, want v=1 b=%h c=%b t=%h",
                   out_valid, out_b, out_carry, out_tag, hold_b, hold_c, hold_tag);
        end
      end
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_in_ready: got %b want 0", in_ready);
        end
        stall--;
      end else if (out_valid) begin
        got++;
        vectors++;
        if (out_tag !== 4'(got) || out_b !== (32'h1 << got) || out_carry !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_result%0d: got b=%h c=%b t=%h, want b=%h c=0 t=%h",
                   got, out_b, out_carry, out_tag, 32'h1 << got, 4'(got));
        end
      end
      if (idx < 4) begin
        in_valid = 1'b1; in_type = 2'b00; in_imm = 1'b0; in_a = 32'h1;
        in_amt = 8'(idx + 1); in_carry = 1'b1; in_tag = 4'(idx + 1);
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got != 4) begin
      miscompares++;
      $display("FAIL bp_count: got %0d results want 4", got);
    end
    begin
      int extra;
      extra = 0;
      repeat (6) begin
        @(negedge clk);
        if (out_valid) extra++;
      end
      vectors++;
      if (extra != 0) begin
        miscompares++;
        $display("FAIL bp_extra: got %0d extra valid cycles want 0", extra);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int waited, extra, lat;
    logic [31:0] b;
    logic c;
    logic [3:0] tg;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_type = 2'b00; in_imm = 1'b1; in_a = 32'h1; in_amt = 8'd1; in_carry = 1'b0; in_tag = 4'h5;
    @(negedge clk);
    in_tag = 4'h6; in_amt = 8'd2;
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_b !== 32'h0 || out_carry !== 1'b0 || out_tag !== 4'h0) begin
      miscompares++;
      $display("FAIL rst_async: got v=%b b=%h c=%b t=%h, want all 0", out_valid, out_b, out_carry, out_tag);
    end
    #1 rst_n = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL rst_flush: got %0d valid cycles after reset want 0", extra);
    end
    run_op(2'b01, 1'b0, 32'hF0000000, 8'd4, 1'b0, 4'h9, b, c, tg, lat);
    vectors++;
    if (b !== 32'h0F000000 || c !== 1'b0 || tg !== 4'h9 || lat != STAGES) begin
      miscompares++;
      $display("FAIL rst_after: got b=%h c=%b t=%h lat=%0d, want b=0F000000 c=0 t=9 lat=%0d",
               b, c, tg, lat, STAGES);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] a, b, eb;
    logic c, ec, cin, imm;
    logic [1:0] ty;
    logic [3:0] tg;
    int lat;
    for (int n = 0; n < 256; n++) begin
      ty  = 2'(n);
      imm = n[2];
      a   = $urandom;
      cin = 1'($urandom_range(0, 1));
      ref_shift(ty, imm, a, 8'(n), cin, eb, ec);
      run_op(ty, imm, a, 8'(n), cin, 4'(n), b, c, tg, lat);
      vectors++;
      if (b !== eb || c !== ec || tg !== 4'(n) || lat != STAGES) begin
        miscompares++;
        $display("FAIL sweep ty=%0d imm=%b amt=%0d a=%h cin=%b: got b=%h c=%b lat=%0d, want b=%h c=%b lat=%0d",
                 ty, imm, n, a, cin, b, c, lat, eb, ec, STAGES);
      end
    end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_reg();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
